// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if: command handshake, run controls and status of the counter sequencer
interface counter_seq_ctrl_if #(parameter int WIDTH = 4, parameter int STEP_W = 8) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic              cmd_dir;
  logic [WIDTH-1:0]  cmd_data;
  logic [STEP_W-1:0] cmd_steps;
  logic              pause;
  logic              abort;
  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              done;
  logic              wrap;
  modport master (output cmd_valid, cmd_op, cmd_dir, cmd_data, cmd_steps, pause, abort,
                  input cmd_ready, count, busy, done, wrap);
  modport slave (input cmd_valid, cmd_op, cmd_dir, cmd_data, cmd_steps, pause, abort,
                 output cmd_ready, count, busy, done, wrap);
endinterface

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven LOAD/RUN sequencer for an up/down counter with pause, abort and wrap status
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int STEP_W = 8
) (
  input logic clk,
  input logic rst,
  counter_seq_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]        state, nxt;
  logic              ready, dir, wrap;
  logic [WIDTH-1:0]  count;
  logic [STEP_W-1:0] remaining;
  logic              acc, is_load, is_run, stepping;
  assign acc      = state == IDLE && bus.cmd_valid && ready;
  assign is_load  = bus.cmd_op == 2'b01;
  assign is_run   = bus.cmd_op == 2'b10;
  assign stepping = state == RUN && !bus.abort && !bus.pause;
  always_comb begin
    nxt = state == IDLE ? ((acc && (is_load || is_run)) ? ((is_run && bus.cmd_steps != '0) ? RUN : DONE) : IDLE) :
          state == RUN  ? (bus.abort ? IDLE : (stepping && remaining == STEP_W'(1)) ? DONE : RUN) :
          IDLE;
  end
  // ready is registered so it stays low through reset and rises the cycle after release
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ready     <= 1'b0;
      count     <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state <= nxt;
      ready <= nxt == IDLE;
      wrap  <= stepping && (dir ? &count : ~|count);
      if (acc && is_load) count <= bus.cmd_data;
      if (stepping) count <= dir ? count + 1'b1 : count - 1'b1;
      if (acc && is_run) begin
        dir       <= bus.cmd_dir;
        remaining <= bus.cmd_steps;
      end else if (stepping) remaining <= remaining - 1'b1;
      else if (state == RUN && bus.abort) remaining <= '0;
    end
  end
  assign bus.cmd_ready = ready;
  assign bus.count     = count;
  assign bus.busy      = state == RUN;
  assign bus.done      = state == DONE;
  assign bus.wrap      = wrap;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed and randomized checks of the counter sequencer against a step-counting model
module tb_counter_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_count = 0;
  counter_seq_ctrl_if #(.WIDTH(4), .STEP_W(8)) bus ();
  counter_seq_ctrl #(.WIDTH(4), .STEP_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input int d);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_data = 4'(d);
    tick();
    bus.cmd_valid = 1'b0;
    m_count = d;
    chk("load_count", bus.count, m_count);
    chk("load_done", bus.done, 1);
    chk("load_ready", bus.cmd_ready, 0);
    chk("load_busy", bus.busy, 0);
    chk("load_wrap", bus.wrap, 0);
    tick();
    chk("load_done_clr", bus.done, 0);
    chk("load_ready_back", bus.cmd_ready, 1);
  endtask
  // The model counts completed steps and derives count and wrap arithmetically from the start value.
  task automatic run_cmd(input bit d, input int n, input int pstep, input int plen, input int astep, input bit rnd);
    int k = 0;
    int hold = 0;
    int exp_wrap = 0;
    bit pz, ab;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_dir = d; bus.cmd_steps = 8'(n);
    tick();
    bus.cmd_valid = 1'b0;
    if (n == 0) begin
      chk("run0_busy", bus.busy, 0);
      chk("run0_done", bus.done, 1);
      chk("run0_count", bus.count, m_count);
      tick();
      chk("run0_done_clr", bus.done, 0);
      chk("run0_ready", bus.cmd_ready, 1);
      return;
    end
    while (k < n) begin
      chk("run_busy", bus.busy, 1);
      chk("run_done", bus.done, 0);
      chk("run_ready", bus.cmd_ready, 0);
      chk("run_count", bus.count, m_count);
      chk("run_wrap", bus.wrap, exp_wrap);
      ab = (k == astep);
      pz = 1'b0;
      if (hold > 0) begin
        pz = 1'b1;
        hold--;
      end else if (rnd) pz = ($urandom_range(0, 3) == 0);
      bus.abort = ab; bus.pause = pz;
      tick();
      bus.abort = 1'b0; bus.pause = 1'b0;
      if (ab) begin
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_ready", bus.cmd_ready, 1);
        chk("abort_count", bus.count, m_count);
        chk("abort_wrap", bus.wrap, 0);
        return;
      end
      exp_wrap = 0;
      if (!pz) begin
        exp_wrap = d ? (m_count == 15) : (m_count == 0);
        m_count = (m_count + (d ? 1 : 15)) % 16;
        k++;
        if (k == pstep) hold = plen;
      end
    end
    chk("end_busy", bus.busy, 0);
    chk("end_done", bus.done, 1);
    chk("end_ready", bus.cmd_ready, 0);
    chk("end_count", bus.count, m_count);
    chk("end_wrap", bus.wrap, exp_wrap);
    tick();
    chk("post_done", bus.done, 0);
    chk("post_ready", bus.cmd_ready, 1);
    chk("post_wrap", bus.wrap, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_dir = 1'b0;
    bus.cmd_data = '0; bus.cmd_steps = '0; bus.pause = 1'b0; bus.abort = 1'b0;
    repeat (3) tick();
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wrap", bus.wrap, 0);
    rst = 1'b1;
    tick();
    chk("rel_ready", bus.cmd_ready, 1);
    load(4'hA);
    load(4'hE);
    run_cmd(1'b1, 3, -1, 0, -1, 1'b0);
    load(4'h1);
    run_cmd(1'b0, 5, 2, 2, -1, 1'b0);
    load(4'h0);
    run_cmd(1'b1, 10, -1, 0, 4, 1'b0);
    run_cmd(1'b1, 0, -1, 0, -1, 1'b0);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_steps = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held_done", bus.done, (i % 2 == 0));
      chk("held_ready", bus.cmd_ready, (i % 2 == 1));
      chk("held_busy", bus.busy, 0);
      chk("held_count", bus.count, m_count);
    end
    bus.cmd_valid = 1'b0;
    for (int op = 0; op < 4; op += 3) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = 2'(op); bus.cmd_data = 4'h9;
      tick();
      bus.cmd_valid = 1'b0;
      chk("nop_ready", bus.cmd_ready, 1);
      chk("nop_done", bus.done, 0);
      chk("nop_count", bus.count, m_count);
    end
    load(4'h0);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_dir = 1'b1; bus.cmd_steps = 8'd10;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (7) tick();
    chk("mid_count", bus.count, 7);
    chk("mid_busy", bus.busy, 1);
    rst = 1'b0;
    tick();
    chk("mrst_count", bus.count, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_ready", bus.cmd_ready, 0);
    rst = 1'b1;
    tick();
    chk("mrel_ready", bus.cmd_ready, 1);
    chk("mrel_done", bus.done, 0);
    m_count = 0;
    load(4'h3);
    for (int t = 0; t < 25; t++) begin
      int n;
      int ab;
      if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, 15)));
      n = int'($urandom_range(0, 20));
      ab = ($urandom_range(0, 3) == 0 && n > 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_cmd(1'($urandom_range(0, 1)), n, -1, 0, ab, 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Command-driven sequencer for the team's 4-bit up/down counter datapath.
- Accepts LOAD and RUN commands over a valid/ready handshake.
- Steps the count a programmed number of times in a chosen direction, with pause and abort controls.
- Reports busy, done and wrap status to the surrounding control logic.

Parameters:
WIDTH, 4, counter width in bits; count wraps modulo 2^WIDTH
STEP_W, 8, width of the step-count field; maximum RUN length is 2^STEP_W-1

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset, sampled on rising edge of clk)
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  2  00 NOP, 01 LOAD, 10 RUN, 11 reserved (treated as NOP)
cmd_dir  input  1  RUN direction: 1 up, 0 down
cmd_data  input  WIDTH  LOAD value
cmd_steps  input  STEP_W  RUN step count
pause  input  1  freezes an active RUN while high
abort  input  1  terminates an active RUN
count  output  WIDTH  current counter value
busy  output  1  high while in RUN state
done  output  1  one-cycle pulse on LOAD or RUN completion
wrap  output  1  one-cycle pulse when count rolls over

Behaviour:
- Reset: rst low at a rising edge sets state=IDLE, count=0, remaining=0, busy=0, done=0, wrap=0.
  - cmd_ready=1 from the cycle after reset releases.
  - Reset mid-RUN discards the RUN: no done, count=0.
- States: IDLE, RUN, DONE. cmd_ready = (state==IDLE). busy = (state==RUN). All outputs registered or decoded from state.
- Accept: a command is accepted at edge E0 where cmd_valid & cmd_ready. cmd_op NOP or reserved is consumed with no effect.
- LOAD: at E0, count<=cmd_data and state->DONE.
  - done=1 for the one cycle after E0; state returns to IDLE at E0+1.
  - Wrap is never raised by LOAD.
- RUN, cmd_steps=0: at E0, state->DONE directly. count unchanged; done pulses exactly as for LOAD.
- RUN, cmd_steps=N>0:
  - At E0: latch dir, remaining<=N, state->RUN.
  - Each subsequent edge with pause=0 and abort=0: count<=count±1 (mod 2^WIDTH), remaining<=remaining-1.
  - On the edge where remaining goes 1->0: state->DONE.
  - Count therefore changes on edges E1..EN (while unpaused). done=1 in the cycle after EN; IDLE at EN+1. Total unpaused latency from accept to done = N+1 edges.
- pause: high during RUN holds count, remaining and state. Ignored in IDLE and DONE.
- abort: high during RUN moves the state to IDLE at the next edge.
  - count holds its current value; no step occurs on that edge.
  - done is not pulsed; remaining<=0.
  - Priority: abort > pause > step. abort is ignored in IDLE and DONE.
- Wrap:
  - Up-step from 2^WIDTH-1 to 0, or down-step from 0 to 2^WIDTH-1, sets wrap=1 for exactly the cycle in which count shows the wrapped value.
  - Otherwise wrap=0.
- A command is never accepted in RUN or DONE: cmd_ready=0, and cmd_valid is held by the requester.
- Back-to-back: a new command may be accepted in the first IDLE cycle after DONE.

Test Plan:
- Reset then LOAD 4'hA -> count=10 in the cycle after accept, done=1 for exactly one cycle, cmd_ready=0 for one cycle, then back to 1.
- LOAD 4'hE, RUN up steps=3 -> count 15, 0 (wrap=1 that cycle), 1. busy=1 for 3 cycles; done pulses once on the following cycle; final count=1.
- LOAD 4'h1, RUN down steps=5 with pause high for 2 cycles after the 2nd step -> count 0, 15 (wrap=1), held at 15 for 2 cycles, then 14, 13, 12. done after the 5th step; total busy=7 cycles.
- RUN up steps=10 from 0, abort after 4th step -> count stays 4, state IDLE next cycle, done never asserted, cmd_ready=1.
- RUN steps=0 -> count unchanged, busy never high, done pulses the cycle after accept. cmd_valid held high through RUN/DONE is accepted only once per IDLE cycle.
- Drive rst low during RUN at count=7 -> count=0, busy=0, done=0 after that edge; rst high again -> cmd_ready=1 on the next cycle, next LOAD works normally.
